// File: rtl/pgm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pgm_pkg
// Description : Shared types and constants for the PGM graphics read port.
// Revision    : 1.0 - initial release
// ============================================================================
package pgm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FILL  = 2'd2
    } pgm_state_t;

    localparam logic [28:0] c_GFX_BASE_DEFAULT = 29'h0300000;

endpackage
`default_nettype wire

// File: rtl/pgm_gfx_line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pgm_gfx_line_buf
// Description : One cache line of BURST x 64-bit words; sync write, comb read.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_gfx_line_buf #(
    parameter int unsigned BURST = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [63:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [BURST];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pgm_gfx_rd_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pgm_gfx_rd_port
// Description : Single-line read buffer fetching graphics ROM bursts from DDR.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_gfx_rd_port
    import pgm_pkg::*;
#(
    parameter int unsigned BURST    = 4,
    parameter logic [28:0] GFX_BASE = c_GFX_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        rd,
    input  logic [28:0] addr,
    output logic [63:0] dout,
    output logic        busy,
    output logic        ddr_rd,
    output logic [28:0] ddr_addr,
    output logic [7:0]  ddr_burstcnt,
    input  logic        ddr_busy,
    input  logic [63:0] ddr_dout,
    input  logic        ddr_dout_ready
);

    localparam int unsigned LB          = $clog2(BURST);
    localparam int unsigned AW          = (LB > 0) ? LB : 1;
    localparam int unsigned TW          = 29 - LB;
    localparam logic [28:0] c_WORD_MASK = 29'(BURST - 1);

    pgm_state_t    r_state;
    pgm_state_t    w_state_nxt;
    logic          r_valid;
    logic          r_discard;
    logic [TW-1:0] r_tag;
    logic [TW-1:0] r_line;
    logic [28:0]   r_ddr_addr;
    logic [AW-1:0] r_beat;

    logic [TW-1:0] w_addr_line;
    logic [AW-1:0] w_word;
    logic          w_hit;
    logic          w_we;
    logic          w_last;

    assign w_addr_line = addr[28:LB];

    generate
        if (LB > 0) begin : g_multi_word
            assign w_word = addr[AW-1:0];
        end else begin : g_single_word
            assign w_word = '0;
        end
    endgenerate

    assign w_hit  = r_valid && (r_tag == w_addr_line) && (r_state == IDLE);
    // Beats are only accepted while filling and never during reset
    assign w_we   = (r_state == FILL) && ddr_dout_ready && reset;
    assign w_last = (r_beat == AW'(BURST - 1));

    always_ff @(posedge clk) begin : p_state_reg
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_state_nxt
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (rd && !w_hit)  w_state_nxt = ISSUE;
            ISSUE:   if (!ddr_busy)     w_state_nxt = FILL;
            FILL:    if (w_we && w_last) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin : p_outputs
        ddr_rd = (r_state == ISSUE);
        busy   = (rd && !w_hit) || (r_state != IDLE);
    end

    always_ff @(posedge clk) begin : p_datapath
        if (!reset) begin
            r_valid    <= 1'b0;
            r_discard  <= 1'b0;
            r_ddr_addr <= '0;
            r_beat     <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (flush) begin
                    r_valid <= 1'b0;
                end
                if (rd && !w_hit) begin
                    r_line     <= w_addr_line;
                    r_ddr_addr <= GFX_BASE + (addr & ~c_WORD_MASK);
                    r_beat     <= '0;
                    r_discard  <= 1'b0;
                end
            end else if (flush) begin
                // Fetch in flight: let it land but never mark it valid
                r_discard <= 1'b1;
            end
            if (w_we) begin
                r_beat <= r_beat + AW'(1);
                if (w_last) begin
                    r_tag     <= r_line;
                    r_valid   <= !(r_discard || flush);
                    r_discard <= 1'b0;
                end
            end
        end
    end

    assign ddr_addr     = r_ddr_addr;
    assign ddr_burstcnt = 8'(BURST);

    pgm_gfx_line_buf #(
        .BURST (BURST),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_beat),
        .i_wdata (ddr_dout),
        .i_raddr (w_word),
        .o_rdata (dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_pgm_gfx_rd_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pgm_gfx_rd_port
// Description : Self-checking bench for pgm_gfx_rd_port with a DDR responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pgm_gfx_rd_port;

    localparam int unsigned BURST     = 4;
    localparam int unsigned LB        = 2;
    localparam logic [28:0] BASE      = 29'h0300000;
    localparam logic [28:0] BASE2     = 29'h1FFFFFFC;
    localparam logic [28:0] WORD_MASK = 29'(BURST - 1);
    localparam int          TMO       = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst_n_main = 1'b0;
    logic        rst_pulse  = 1'b0;
    logic        flush;
    logic        flush_idle = 1'b0;
    logic        flush_fill = 1'b0;
    logic        rd = 1'b0;
    logic [28:0] addr = '0;
    logic [63:0] dout;
    logic        busy;
    logic        ddr_rd;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic        ddr_busy = 1'b0;
    logic [63:0] ddr_dout = '0;
    logic        ddr_dout_ready = 1'b0;

    logic [63:0] w2_dout;
    logic        w2_busy, w2_ddr_rd;
    logic [28:0] w2_ddr_addr;
    logic [7:0]  w2_burstcnt;

    assign reset = rst_n_main && !rst_pulse;
    assign flush = flush_idle || flush_fill;

    always #5 clk = ~clk;

    pgm_gfx_rd_port #(.BURST(BURST), .GFX_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush), .rd(rd), .addr(addr),
        .dout(dout), .busy(busy), .ddr_rd(ddr_rd), .ddr_addr(ddr_addr),
        .ddr_burstcnt(ddr_burstcnt), .ddr_busy(ddr_busy), .ddr_dout(ddr_dout),
        .ddr_dout_ready(ddr_dout_ready)
    );

    pgm_gfx_rd_port #(.BURST(BURST), .GFX_BASE(BASE2)) dut_wrap (
        .clk(clk), .reset(reset), .flush(flush), .rd(rd), .addr(addr),
        .dout(w2_dout), .busy(w2_busy), .ddr_rd(w2_ddr_rd), .ddr_addr(w2_ddr_addr),
        .ddr_burstcnt(w2_burstcnt), .ddr_busy(ddr_busy), .ddr_dout(ddr_dout),
        .ddr_dout_ready(ddr_dout_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ddr_word(input logic [28:0] w);
        return {3'b101, w, 3'b011, w ^ 29'h0ABCDEF};
    endfunction

    // Reference model and responder knobs
    logic        m_valid = 1'b0;
    logic [26:0] m_tag   = '0;
    logic [28:0] exp_cmd_addr = '0;
    logic [28:0] cmd_addr = '0;
    logic [28:0] last_addr2 = '0;
    int cmd_count = 0, issue_cyc = 0, beats_left = 0, beat_idx = 0, beat_wait = 0;
    int arm_flush_beat = -1, arm_rst_beat = -1, flush_fired = 0, rst_fired = 0;
    int force_bp = 0, beat_delay = 0;
    bit bp_en = 1'b0, gap_en = 1'b0;

    // DDR responder: all decisions made 1ns after the clock edge
    always begin
        @(posedge clk);
        #1;
        flush_fill     = 1'b0;
        rst_pulse      = 1'b0;
        ddr_dout_ready = 1'b0;
        if (beats_left > 0) begin
            if (beat_wait > 0) begin
                beat_wait--;
            end else if (!gap_en || $urandom_range(0, 3) != 0) begin
                ddr_dout_ready = 1'b1;
                ddr_dout = ddr_word(cmd_addr + 29'(beat_idx));
                if (beat_idx == arm_flush_beat) begin
                    flush_fill = 1'b1; arm_flush_beat = -1; flush_fired++;
                end
                if (beat_idx == arm_rst_beat) begin
                    rst_pulse = 1'b1; arm_rst_beat = -1; rst_fired++;
                end
                beat_idx++;
                beats_left--;
            end
        end
        if (ddr_rd) begin
            issue_cyc++;
            check("ddr_addr", 64'(ddr_addr), 64'(exp_cmd_addr));
            check("burstcnt", 64'(ddr_burstcnt), 64'(BURST));
            check("wrap_addr", 64'(w2_ddr_addr), 64'(29'(exp_cmd_addr - BASE + BASE2)));
            check("outstanding", 64'(beats_left), 64'd0);
            if (force_bp > 0) begin
                ddr_busy = 1'b1;
                force_bp--;
            end else begin
                ddr_busy = bp_en ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (!ddr_busy) begin
                cmd_count++;
                cmd_addr   = ddr_addr;
                last_addr2 = w2_ddr_addr;
                beats_left = BURST;
                beat_idx   = 0;
                beat_wait  = bp_en ? int'($urandom_range(0, 3)) : beat_delay;
            end
        end else begin
            ddr_busy = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_read(input logic [28:0] a, output int cycles);
        bit exp_hit;
        int c0, f0;
        exp_hit = m_valid && (m_tag == a[28:LB]);
        c0 = cmd_count;
        f0 = flush_fired;
        exp_cmd_addr = BASE + (a & ~WORD_MASK);
        @(posedge clk);
        #1;
        rd = 1'b1;
        addr = a;
        #1;
        check("busy_first", 64'(busy), exp_hit ? 64'd0 : 64'd1);
        cycles = 0;
        while (busy && cycles < TMO) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check("read_timeout", 64'(cycles >= TMO), 64'd0);
        check("dout", dout, ddr_word(BASE + a));
        check("cmds", 64'(cmd_count - c0),
              exp_hit ? 64'd0 : 64'(1 + (flush_fired - f0)));
        m_valid = 1'b1;
        m_tag   = a[28:LB];
        rd = 1'b0;
        #1;
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic idle_flush();
        @(posedge clk);
        #1;
        flush_idle = 1'b1;
        @(posedge clk);
        #1;
        flush_idle = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        int cyc, r0, i0;
        logic [28:0] a;

        // Reset: busy follows rd, no DDR activity
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy_rd0", 64'(busy), 64'd0);
        check("rst_ddr_rd", 64'(ddr_rd), 64'd0);
        check("rst_ddr_addr", 64'(ddr_addr), 64'd0);
        rd = 1'b1;
        #1;
        check("rst_busy_rd1", 64'(busy), 64'd1);
        rd = 1'b0;
        @(posedge clk);
        #1;
        rst_n_main = 1'b1;

        // Cold miss with best-case timing: beats at cycles 4..7, ready at 8
        beat_delay = 2;
        do_read(29'h10, cyc);
        check("cold_latency", 64'(cyc), 64'd8);
        check("cold_cmd_addr", 64'(cmd_addr), 64'h300010);
        beat_delay = 0;

        // Hits on the rest of the line
        for (int k = 1; k < 4; k++) begin
            do_read(29'h10 + 29'(k), cyc);
            check("hit_latency", 64'(cyc), 64'd0);
        end

        // Backpressure for 5 cycles in ISSUE
        force_bp = 5;
        i0 = issue_cyc;
        do_read(29'h25, cyc);
        check("bp_issue_cycles", 64'(issue_cyc - i0), 64'd6);

        // Flush during fill at beat 2: line discarded, refetched
        arm_flush_beat = 2;
        do_read(29'h42, cyc);
        check("flush_fired", 64'(flush_fired), 64'd1);
        do_read(29'h43, cyc);

        // Reset at beat 1 of a fill; stray beats must be ignored
        exp_cmd_addr = BASE + 29'h20;
        arm_rst_beat = 1;
        r0 = rst_fired;
        @(posedge clk);
        #1;
        rd = 1'b1;
        addr = 29'h20;
        cyc = 0;
        while (rst_fired == r0 && cyc < TMO) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("rst_timeout", 64'(cyc >= TMO), 64'd0);
        rd = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_ddr_rd", 64'(ddr_rd), 64'd0);
        cyc = 0;
        while (beats_left > 0 && cyc < TMO) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("post_rst_busy_strays", 64'(busy), 64'd0);
        m_valid = 1'b0;
        do_read(29'h20, cyc);

        // Address wrap on the second instance
        do_read(29'h8, cyc);
        check("wrap_ddr_addr", 64'(last_addr2), 64'h4);

        // Idle flush forces a refetch
        idle_flush();
        do_read(29'h9, cyc);

        // Randomized traffic
        bp_en = 1'b1;
        gap_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = 29'($urandom);
            end else begin
                a = 29'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
            end
            if ($urandom_range(0, 4) == 0) begin
                arm_flush_beat = int'($urandom_range(0, BURST - 1));
            end
            do_read(a, cyc);
            if ($urandom_range(0, 5) == 0) begin
                idle_flush();
            end
        end
        arm_flush_beat = -1;

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pgm_gfx_rd_port.md
PGM_GFX_RD_PORT -- requirements
Module: pgm_gfx_rd_port

Interface
REQ-001 Parameter BURST, default 4, meaning 64-bit words per DDR fetch; legal values are powers of two from 1 to 8.
REQ-002 Parameter GFX_BASE, default 29'h0300000, meaning the DDR word offset of graphics ROM.
REQ-003 Ports (clock and reset first):
 clk  in  1  single clock for all logic;
 reset  in  1  synchronous, active-low reset;
 flush  in  1  one-cycle pulse that invalidates the buffer;
 rd  in  1  client read request, held until satisfied;
 addr  in  29  client 64-bit word address;
 dout  out  64  data for addr;
 busy  out  1  client must wait while high;
 ddr_rd  out  1  DDR read command;
 ddr_addr  out  29  DDR word address;
 ddr_burstcnt  out  8  DDR burst length;
 ddr_busy  in  1  DDR waitrequest;
 ddr_dout  in  64  DDR read data;
 ddr_dout_ready  in  1  DDR read-data beat valid.

Function
REQ-004 The block SHALL hold one aligned line of BURST words with tag = addr[28:log2(BURST)] and a valid bit.
REQ-005 Hit means valid=1, tag equals the addr line, and state is IDLE; on a hit, busy SHALL be 0 in the same cycle (combinational) and dout SHALL equal line word addr[log2(BURST)-1:0] (combinational word select).
REQ-006 busy SHALL equal (rd AND NOT hit) OR (state != IDLE); with rd=0, busy SHALL be 0 in IDLE.
REQ-007 State machine IDLE/ISSUE/FILL:
 IDLE -> ISSUE on rd AND miss, latching the line address;
 ISSUE holds ddr_rd=1 with a stable ddr_addr and ddr_burstcnt until a cycle with ddr_busy=0, then goes to FILL with ddr_rd=0 the next cycle;
 FILL -> IDLE after BURST ddr_dout_ready beats.
REQ-008 ddr_addr SHALL be (GFX_BASE + {line address, log2(BURST) zeros}) mod 2^29; ddr_burstcnt SHALL be BURST zero-extended.
REQ-009 In FILL, beat k (0-based) SHALL be written to line word k; tag SHALL be updated and valid set on the last beat; the FILL->IDLE transition occurs on that same last-beat edge.
REQ-010 Client changing addr or dropping rd during ISSUE/FILL: the fetch SHALL complete unchanged; hit is re-evaluated in IDLE against the current addr.
REQ-011 flush in IDLE SHALL clear valid next cycle; flush in ISSUE/FILL SHALL let the fetch finish but leave valid=0 (sticky discard flag); flush and a last beat in the same cycle SHALL result in valid=0.
REQ-012 ddr_dout_ready beats arriving in IDLE or ISSUE SHALL be ignored.
REQ-013 ddr_rd SHALL never be asserted outside ISSUE; at most one burst SHALL be outstanding.
REQ-014 Best-case miss latency: rd rises at cycle 0; ddr_rd=1 at cycle 1; with ddr_busy=0, FILL from cycle 2; with the first beat at cycle n, busy=0 at cycle n+BURST.

Reset
REQ-015 While reset=0 at a clk edge: state=IDLE, valid=0, discard flag=0, ddr_rd=0, ddr_addr=0, line contents unchanged; busy follows REQ-006, so busy=rd.
REQ-016 Reset mid-ISSUE/FILL SHALL abort the fetch immediately; leftover beats SHALL be ignored per REQ-012.

Structure
REQ-017 Package pgm_pkg SHALL hold the state enum (IDLE, ISSUE, FILL) and the GFX_BASE default constant.
REQ-018 Line storage SHALL be a sub-module pgm_gfx_line_buf: BURST x 64 bits, one synchronous write port, one combinational read port. All other logic SHALL be in pgm_gfx_rd_port.

Verification
REQ-019 Cold miss, BURST=4: addr=29'h10 with ddr_busy=0, beats at cycles 4..7 -> ddr_addr=29'h300010, burstcnt=4, busy=0 at cycle 8, dout=beat 0.
REQ-020 Hits: after REQ-019, addr 29'h11..29'h13 -> busy=0 the same cycle, dout=beats 1..3, no ddr_rd.
REQ-021 Backpressure: ddr_busy=1 for 5 cycles in ISSUE -> ddr_rd and ddr_addr stable throughout, a single command accepted.
REQ-022 Flush during FILL at beat 2 -> fill completes, next rd to the same addr misses and refetches.
REQ-023 Reset asserted at beat 1 of FILL, then deasserted -> state IDLE, stray beats 2..3 ignored, next rd refetches.
REQ-024 Address wrap: GFX_BASE=29'h1FFFFFFC, addr=29'h8 -> ddr_addr=29'h4.
